// File: rtl/demux_2_stream_pkg.sv
// Shared constants and helpers for the 1-to-2 stream demultiplexer.
// Default sizes and the occupancy-counter width live here so every file sizes its counts the same way.
package selector_pkg;

  localparam int DEFAULT_BUS   = 4;
  localparam int DEFAULT_DEPTH = 2;

  // One extra bit so a count can represent DEPTH itself (full), not just 0..DEPTH-1.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/demux_2_stream_if.sv
// Stream bundle for demux_2_stream: one input stream, two output streams, occupancy counts.
// master drives the input stream and the consumer readies; slave is the demux itself.
interface demux_2_stream_if
  import selector_pkg::*;
#(
  parameter int bus   = DEFAULT_BUS,
  parameter int DEPTH = DEFAULT_DEPTH
);

  localparam int CW = count_width(DEPTH);

  logic [bus-1:0] d;
  logic           selector;
  logic           in_valid;
  logic           in_ready;

  logic [bus-1:0] out0;
  logic           out0_valid;
  logic           out0_ready;

  logic [bus-1:0] out1;
  logic           out1_valid;
  logic           out1_ready;

  logic [CW-1:0]  count0;
  logic [CW-1:0]  count1;

  modport master (
    output d, selector, in_valid, out0_ready, out1_ready,
    input  in_ready, out0, out0_valid, out1, out1_valid, count0, count1
  );

  modport slave (
    input  d, selector, in_valid, out0_ready, out1_ready,
    output in_ready, out0, out0_valid, out1, out1_valid, count0, count1
  );

endinterface

// File: rtl/demux_2_stream_fifo.sv
// Small register FIFO used once per demux output; head word is presented straight from storage.
// Full/empty come from the occupancy count, so pointers simply wrap modulo DEPTH.
module stream_fifo
  import selector_pkg::*;
#(
  parameter  int bus   = DEFAULT_BUS,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int CW    = count_width(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [bus-1:0] wdata,
  input  logic           pop,
  output logic [bus-1:0] rdata,
  output logic [CW-1:0]  count
);

  logic [bus-1:0]   mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic [DEPTH-1:0] wen;
  logic             push_ok;
  logic             pop_ok;

  // Guards here keep the FIFO self-protecting even if a caller misbehaves.
  assign pop_ok  = pop  & (count_reg != '0);
  assign push_ok = push & (count_reg < CW'(DEPTH));

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wen
      assign wen[gi] = push_ok & (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wen[i]) begin
          mem_reg[i] <= wdata;
        end
      end
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
    end
  end

  assign rdata = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/demux_2_stream.sv
// Registered 1-to-2 stream demultiplexer: selector steers each accepted word into one of two FIFOs.
// in_ready depends only on selector and the registered counts, never on the consumer readies.
module demux_2_stream
  import selector_pkg::*;
#(
  parameter  int bus   = DEFAULT_BUS,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int CW    = count_width(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  demux_2_stream_if.slave s
);

  logic [1:0]     push;
  logic [1:0]     pop;
  logic [1:0]     space;
  logic [1:0]     out_ready;
  logic [bus-1:0] rdata [2];
  logic [CW-1:0]  cnt   [2];
  logic           accept;

  assign out_ready = {s.out1_ready, s.out0_ready};
  assign accept    = s.in_valid & s.in_ready;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign space[gi] = cnt[gi] < CW'(DEPTH);
      assign push[gi]  = accept & (s.selector == 1'(gi));
      assign pop[gi]   = (cnt[gi] != '0) & out_ready[gi];

      stream_fifo #(
        .bus   (bus),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push[gi]),
        .wdata (s.d),
        .pop   (pop[gi]),
        .rdata (rdata[gi]),
        .count (cnt[gi])
      );
    end
  endgenerate

  assign s.in_ready   = s.selector ? space[1] : space[0];

  assign s.out0       = rdata[0];
  assign s.out0_valid = cnt[0] != '0;
  assign s.count0     = cnt[0];

  assign s.out1       = rdata[1];
  assign s.out1_valid = cnt[1] != '0;
  assign s.count1     = cnt[1];

endmodule
